// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encodings, parity modes and the
// oversample-tick divider calculation reused by the transmit side.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } rx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Floor division: the tick rate is slightly fast, never slow.
    function automatic int calc_tick_div(input int clk_freq_hz, input int baud,
                                         input int oversample);
        return clk_freq_hz / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle pulse every TICK_DIV clocks while
// enabled, counter parked at zero when disabled.
module uart_baud_tick #(
    parameter int TICK_DIV = 651
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d  = cnt_q;
        tick_o = 1'b0;
        if (!en_i) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(TICK_DIV - 1)) begin
            cnt_d  = '0;
            tick_o = 1'b1;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 16x-style oversampling, mid-bit sampling,
// optional parity, 1/2 stop bits, valid/ready output register with flags.
//
// state    | meaning
// S_IDLE   | line idle, waiting for a low sample on a tick
// S_START  | qualifying the start bit at its centre (glitch rejection)
// S_DATA   | sampling payload bits, LSB first
// S_PARITY | sampling the parity bit
// S_STOP   | sampling stop bit(s); last one commits the frame
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int BAUD        = 9600,
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] dout_o,
    output logic                 dout_valid_o,
    input  logic                 dout_ready_i,
    output logic                 frame_err_o,
    output logic                 parity_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
);

    localparam int   TICK_DIV = calc_tick_div(CLK_FREQ_HZ, BAUD, OVERSAMPLE);
    localparam int   OSW      = $clog2(OVERSAMPLE);
    localparam int   BW       = $clog2(DATA_BITS);
    localparam logic PAR_EXP  = (PARITY == PAR_ODD);

    localparam logic [OSW-1:0] OS_HALF = OSW'(OVERSAMPLE / 2 - 1);
    localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);

    logic                 sync1_q, rx_s;
    logic                 tick;
    rx_state_e            state_q, state_d;
    logic [OSW-1:0]       os_q, os_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 fe_q, fe_d;
    logic                 pe_q, pe_d;
    logic                 commit_q, commit_d;

    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 perr_q, perr_d;
    logic                 ovr_q, ovr_d;

    uart_baud_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (en_i),
        .tick_o (tick)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            sync1_q <= rx_i;
            rx_s    <= sync1_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        os_d     = os_q;
        bit_d    = bit_q;
        stop_d   = stop_q;
        shift_d  = shift_q;
        fe_d     = fe_q;
        pe_d     = pe_q;
        commit_d = 1'b0;
        if (!en_i) begin
            state_d = S_IDLE;
            os_d    = '0;
        end else if (tick) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_d = S_START;
                        os_d    = '0;
                    end
                end
                S_START: begin
                    if (os_q == OS_HALF) begin
                        os_d = '0;
                        if (!rx_s) begin
                            state_d = S_DATA;
                            bit_d   = '0;
                            fe_d    = 1'b0;
                            pe_d    = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        os_d = os_q + OSW'(1);
                    end
                end
                S_DATA: begin
                    if (os_q == OS_LAST) begin
                        os_d    = '0;
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        bit_d   = bit_q + BW'(1);
                        if (bit_q == BW'(DATA_BITS - 1)) begin
                            state_d = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
                            stop_d  = 1'b0;
                        end
                    end else begin
                        os_d = os_q + OSW'(1);
                    end
                end
                S_PARITY: begin
                    if (os_q == OS_LAST) begin
                        os_d    = '0;
                        pe_d    = ((^shift_q) ^ rx_s) != PAR_EXP;
                        state_d = S_STOP;
                        stop_d  = 1'b0;
                    end else begin
                        os_d = os_q + OSW'(1);
                    end
                end
                S_STOP: begin
                    if (os_q == OS_LAST) begin
                        os_d = '0;
                        fe_d = fe_q | ~rx_s;
                        // No wait for the end of the stop bit: lets the next start edge resync.
                        if (stop_q == 1'(STOP_BITS - 1)) begin
                            state_d  = S_IDLE;
                            commit_d = 1'b1;
                        end else begin
                            stop_d = stop_q + 1'b1;
                        end
                    end else begin
                        os_d = os_q + OSW'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            os_q     <= '0;
            bit_q    <= '0;
            stop_q   <= 1'b0;
            shift_q  <= '0;
            fe_q     <= 1'b0;
            pe_q     <= 1'b0;
            commit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            os_q     <= os_d;
            bit_q    <= bit_d;
            stop_q   <= stop_d;
            shift_q  <= shift_d;
            fe_q     <= fe_d;
            pe_q     <= pe_d;
            commit_q <= commit_d;
        end
    end

    // A commit in the same cycle as a handshake reloads the register.
    always_comb begin
        dout_d  = dout_q;
        valid_d = valid_q;
        ferr_d  = ferr_q;
        perr_d  = perr_q;
        ovr_d   = ovr_q;
        if (valid_q && dout_ready_i) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
        if (commit_q) begin
            if (!valid_q || dout_ready_i) begin
                dout_d  = shift_q;
                ferr_d  = fe_q;
                perr_d  = pe_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign dout_o       = dout_q;
    assign dout_valid_o = valid_q;
    assign frame_err_o  = ferr_q;
    assign parity_err_o = perr_q;
    assign overrun_o    = ovr_q;
    assign busy_o       = (state_q != S_IDLE);

endmodule
